// File: rtl/npu_pkg.sv
// rtl/npu_pkg.sv - shared tile geometry and scheduler state encoding for the PE array
package npu_pkg;

    localparam int OC_TILE  = 64;
    localparam int ROW_BAND = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_ARM,
        ST_RUN,
        ST_DRAIN,
        ST_NEXT
    } sched_state_t;

endpackage

// File: rtl/tile_iter.sv
// rtl/tile_iter.sv - nested row-band / output-channel tile counters with remainder clamping
module tile_iter #(
    parameter int OC_TILE  = npu_pkg::OC_TILE,
    parameter int ROW_BAND = npu_pkg::ROW_BAND,
    parameter int OC_W     = 10,
    parameter int H_W      = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            init,
    input  logic            advance,
    input  logic [OC_W-1:0] cfg_oc,
    input  logic [H_W-1:0]  cfg_h,
    output logic [OC_W-1:0] oc_base,
    output logic [H_W-1:0]  row_base,
    output logic [7:0]      tile_oc,
    output logic [5:0]      tile_h,
    output logic            last
);

    localparam logic [OC_W:0] OC_STEP  = (OC_W+1)'(OC_TILE);
    localparam logic [H_W:0]  ROW_STEP = (H_W+1)'(ROW_BAND);

    // One extra bit so base + step never wraps near the top of the range.
    logic [OC_W:0] oc_next;
    logic [OC_W:0] oc_rem;
    logic [H_W:0]  row_next;
    logic [H_W:0]  h_rem;

    assign oc_next  = {1'b0, oc_base} + OC_STEP;
    assign row_next = {1'b0, row_base} + ROW_STEP;
    assign oc_rem   = {1'b0, cfg_oc} - {1'b0, oc_base};
    assign h_rem    = {1'b0, cfg_h} - {1'b0, row_base};

    assign tile_oc = (oc_rem >= OC_STEP) ? 8'(OC_TILE) : 8'(oc_rem);
    assign tile_h  = (h_rem >= ROW_STEP) ? 6'(ROW_BAND) : 6'(h_rem);
    assign last    = (oc_next >= {1'b0, cfg_oc}) && (row_next >= {1'b0, cfg_h});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            oc_base  <= '0;
            row_base <= '0;
        end else if (init) begin
            oc_base  <= '0;
            row_base <= '0;
        end else if (advance) begin
            // Advance is never issued on the last tile, so row_next fits in H_W bits here.
            if (oc_next >= {1'b0, cfg_oc}) begin
                oc_base  <= '0;
                row_base <= row_next[H_W-1:0];
            end else begin
                oc_base  <= oc_next[OC_W-1:0];
            end
        end
    end

endmodule

// File: rtl/pe_array_sched.sv
// rtl/pe_array_sched.sv - per-layer tile scheduler sequencing load, PE run and drain handshakes
module pe_array_sched #(
    parameter int OC_TILE  = npu_pkg::OC_TILE,
    parameter int ROW_BAND = npu_pkg::ROW_BAND,
    parameter int OC_W     = 10,
    parameter int H_W      = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            layer_start,
    input  logic [OC_W-1:0] cfg_oc,
    input  logic [H_W-1:0]  cfg_h,
    input  logic [5:0]      cfg_w,
    input  logic [2:0]      cfg_k,
    input  logic [2:0]      cfg_stride,
    output logic            busy,
    output logic            layer_done,
    output logic            cfg_err,
    output logic            load_req,
    input  logic            load_ack,
    output logic            pe_start,
    input  logic            pe_done,
    output logic            drain_req,
    input  logic            drain_ack,
    output logic [7:0]      tile_oc,
    output logic [5:0]      tile_h,
    output logic [OC_W-1:0] tile_oc_base,
    output logic [H_W-1:0]  tile_row_base,
    output logic [2:0]      pe_k,
    output logic [5:0]      pe_w,
    output logic [2:0]      pe_stride
);

    import npu_pkg::*;

    sched_state_t    state;
    sched_state_t    state_nx;
    logic [OC_W-1:0] oc_q;
    logic [H_W-1:0]  h_q;
    logic [5:0]      w_q;
    logic [2:0]      k_q;
    logic [2:0]      stride_q;
    logic            cfg_err_q;
    logic            cfg_ok;
    logic            accept;
    logic            last;

    assign cfg_ok = (cfg_oc != '0) && (cfg_h != '0);
    assign accept = (state == ST_IDLE) && layer_start && cfg_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            oc_q      <= '0;
            h_q       <= '0;
            w_q       <= '0;
            k_q       <= '0;
            stride_q  <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state     <= state_nx;
            cfg_err_q <= (state == ST_IDLE) && layer_start && !cfg_ok;
            if (accept) begin
                oc_q     <= cfg_oc;
                h_q      <= cfg_h;
                w_q      <= cfg_w;
                k_q      <= cfg_k;
                stride_q <= cfg_stride;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (accept)     state_nx = ST_LOAD;
            ST_LOAD:  if (load_ack)   state_nx = ST_START;
            ST_START:                 state_nx = ST_ARM;
            // Wait for the array to drop pe_done so a stale idle level is not taken as completion.
            ST_ARM:   if (!pe_done)   state_nx = ST_RUN;
            ST_RUN:   if (pe_done)    state_nx = ST_DRAIN;
            ST_DRAIN: if (drain_ack)  state_nx = ST_NEXT;
            ST_NEXT:                  state_nx = last ? ST_IDLE : ST_LOAD;
            default:                  state_nx = ST_IDLE;
        endcase
    end

    tile_iter #(
        .OC_TILE  (OC_TILE),
        .ROW_BAND (ROW_BAND),
        .OC_W     (OC_W),
        .H_W      (H_W)
    ) u_tile_iter (
        .clk      (clk),
        .reset    (reset),
        .init     (accept),
        .advance  ((state == ST_NEXT) && !last),
        .cfg_oc   (oc_q),
        .cfg_h    (h_q),
        .oc_base  (tile_oc_base),
        .row_base (tile_row_base),
        .tile_oc  (tile_oc),
        .tile_h   (tile_h),
        .last     (last)
    );

    assign busy       = (state != ST_IDLE);
    assign layer_done = (state == ST_NEXT) && last;
    assign cfg_err    = cfg_err_q;
    assign load_req   = (state == ST_LOAD);
    assign pe_start   = (state == ST_START);
    assign drain_req  = (state == ST_DRAIN);
    assign pe_k       = k_q;
    assign pe_w       = w_q;
    assign pe_stride  = stride_q;

endmodule

// File: tb/tb_pe_array_sched.sv
// tb/tb_pe_array_sched.sv - directed table-driven bench for the PE array tile scheduler
module tb_pe_array_sched;

    localparam int OC_W = 10;
    localparam int H_W  = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            layer_start;
    logic [OC_W-1:0] cfg_oc;
    logic [H_W-1:0]  cfg_h;
    logic [5:0]      cfg_w;
    logic [2:0]      cfg_k;
    logic [2:0]      cfg_stride;
    logic            busy, layer_done, cfg_err, load_req, load_ack;
    logic            pe_start, pe_done, drain_req, drain_ack;
    logic [7:0]      tile_oc;
    logic [5:0]      tile_h;
    logic [OC_W-1:0] tile_oc_base;
    logic [H_W-1:0]  tile_row_base;
    logic [2:0]      pe_k, pe_stride;
    logic [5:0]      pe_w;

    int n_tests = 0;
    int n_fail  = 0;

    pe_array_sched #(.OC_W(OC_W), .H_W(H_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .layer_start   (layer_start),
        .cfg_oc        (cfg_oc),
        .cfg_h         (cfg_h),
        .cfg_w         (cfg_w),
        .cfg_k         (cfg_k),
        .cfg_stride    (cfg_stride),
        .busy          (busy),
        .layer_done    (layer_done),
        .cfg_err       (cfg_err),
        .load_req      (load_req),
        .load_ack      (load_ack),
        .pe_start      (pe_start),
        .pe_done       (pe_done),
        .drain_req     (drain_req),
        .drain_ack     (drain_ack),
        .tile_oc       (tile_oc),
        .tile_h        (tile_h),
        .tile_oc_base  (tile_oc_base),
        .tile_row_base (tile_row_base),
        .pe_k          (pe_k),
        .pe_w          (pe_w),
        .pe_stride     (pe_stride)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int oc, h, w, passes;
        int first_oc, first_h;
        int last_oc, last_h, last_ob, last_rb;
    } layer_vec_t;

    typedef struct {
        int t_oc, t_h, ob, rb;
    } tile_exp_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_layer(input int oc, input int h, input int w, input int k, input int s);
        cfg_oc      = OC_W'(oc);
        cfg_h       = H_W'(h);
        cfg_w       = 6'(w);
        cfg_k       = 3'(k);
        cfg_stride  = 3'(s);
        layer_start = 1'b1;
        tick();
        layer_start = 1'b0;
    endtask

    function automatic logic [63:0] all_outs();
        return {14'd0, busy, layer_done, cfg_err, load_req, pe_start, drain_req,
                tile_oc, tile_h, tile_oc_base, tile_row_base, pe_k, pe_w, pe_stride};
    endfunction

    // Entered in the first LOAD cycle of a tile; leaves one cycle after NEXT.
    task automatic run_tile(input int load_d, input bit stray, input int arm_d, input bit exp_last,
                            input bit restart, input bit abort,
                            output logic [7:0] t_oc, output logic [5:0] t_h,
                            output logic [OC_W-1:0] ob, output logic [H_W-1:0] rb);
        t_oc = tile_oc;
        t_h  = tile_h;
        ob   = tile_oc_base;
        rb   = tile_row_base;
        check("load_req_entry", load_req, 1);
        for (int i = 0; i < load_d; i++) begin
            drain_ack = stray && (i == 1);
            tick();
            drain_ack = 1'b0;
            check("load_req_held", {load_req, pe_start}, 2'b10);
        end
        load_ack = 1'b1;
        tick();
        load_ack = 1'b0;
        check("pe_start_pulse", {pe_start, load_req}, 2'b10);
        tick();
        check("pe_start_once", pe_start, 0);
        for (int i = 0; i < arm_d; i++) begin
            tick();
            check("arm_wait", {pe_start, drain_req, load_req}, 0);
        end
        pe_done = 1'b0;
        tick();
        if (restart) begin
            cfg_oc      = 10'd7;
            cfg_h       = 8'd3;
            cfg_w       = 6'd9;
            cfg_k       = 3'd1;
            cfg_stride  = 3'd1;
            layer_start = 1'b1;
            tick();
            layer_start = 1'b0;
            check("restart_busy", {busy, cfg_err, load_req}, 3'b100);
        end
        if (abort) begin
            #2 reset = 1'b1;
            #1;
            check("reset_mid_run_outs", all_outs(), 0);
            return;
        end
        tick();
        check("run_no_drain", drain_req, 0);
        pe_done = 1'b1;
        tick();
        check("drain_req", drain_req, 1);
        tick();
        check("drain_req_held", drain_req, 1);
        drain_ack = 1'b1;
        tick();
        drain_ack = 1'b0;
        check("layer_done_at_next", {layer_done, busy, drain_req}, {exp_last, 2'b10});
        tick();
        check("after_next", {busy, layer_done, load_req}, {!exp_last, 1'b0, !exp_last});
    endtask

    layer_vec_t vecs[7];
    tile_exp_t  seq130[6];
    tile_exp_t  seq65[4];

    initial begin
        logic [7:0]      t_oc;
        logic [5:0]      t_h;
        logic [OC_W-1:0] ob;
        logic [H_W-1:0]  rb;

        vecs[0] = '{64,   32,  5,  1,   64, 32, 64, 32, 0,   0};
        vecs[1] = '{65,   33,  6,  4,   64, 32, 1,  1,  64,  32};
        vecs[2] = '{1,    1,   7,  1,   1,  1,  1,  1,  0,   0};
        vecs[3] = '{0,    5,   8,  0,   0,  0,  0,  0,  0,   0};
        vecs[4] = '{128,  64,  9,  4,   64, 32, 64, 32, 64,  32};
        vecs[5] = '{5,    0,   10, 0,   0,  0,  0,  0,  0,   0};
        vecs[6] = '{1023, 255, 63, 128, 64, 32, 63, 31, 960, 224};

        seq130[0] = '{64, 32, 0,   0};
        seq130[1] = '{64, 32, 64,  0};
        seq130[2] = '{2,  32, 128, 0};
        seq130[3] = '{64, 8,  0,   32};
        seq130[4] = '{64, 8,  64,  32};
        seq130[5] = '{2,  8,  128, 32};

        seq65[0] = '{64, 32, 0,  0};
        seq65[1] = '{1,  32, 64, 0};
        seq65[2] = '{64, 1,  0,  32};
        seq65[3] = '{1,  1,  64, 32};

        reset = 1'b1; layer_start = 0; cfg_oc = 0; cfg_h = 0; cfg_w = 0; cfg_k = 0; cfg_stride = 0;
        load_ack = 0; drain_ack = 0; pe_done = 1'b1;
        #1;
        check("reset_outs", all_outs(), 0);
        tick();
        tick();
        reset = 1'b0;

        for (int v = 0; v < 7; v++) begin
            start_layer(vecs[v].oc, vecs[v].h, vecs[v].w, 3, 2);
            if (vecs[v].passes == 0) begin
                check("cfg_err_pulse", {cfg_err, busy, load_req}, 3'b100);
                tick();
                check("cfg_err_clear", {cfg_err, busy, load_req}, 3'b000);
                continue;
            end
            check("accept_busy", {busy, load_req, pe_w, pe_k, pe_stride}, {2'b11, 6'(vecs[v].w), 3'd3, 3'd2});
            for (int t = 0; t < vecs[v].passes; t++) begin
                run_tile(1, 0, 0, t == vecs[v].passes - 1, 0, 0, t_oc, t_h, ob, rb);
                if (t == 0)
                    check("first_tile", {t_oc, t_h, ob, rb}, {8'(vecs[v].first_oc), 6'(vecs[v].first_h), 18'd0});
                if (t == vecs[v].passes - 1)
                    check("last_tile", {t_oc, t_h, ob, rb},
                          {8'(vecs[v].last_oc), 6'(vecs[v].last_h), 10'(vecs[v].last_ob), 8'(vecs[v].last_rb)});
            end
        end

        // 130x40 layer: delayed load ack with a stray drain ack, slow pe_done fall, restart during RUN.
        start_layer(130, 40, 17, 5, 3);
        for (int t = 0; t < 6; t++) begin
            run_tile(t == 0 ? 10 : 0, t == 0, t == 1 ? 3 : 0, t == 5, t == 2, 0, t_oc, t_h, ob, rb);
            check("seq130_tile", {t_oc, t_h, ob, rb},
                  {8'(seq130[t].t_oc), 6'(seq130[t].t_h), 10'(seq130[t].ob), 8'(seq130[t].rb)});
        end
        check("seq130_cfg_kept", {pe_w, pe_k, pe_stride}, {6'd17, 3'd5, 3'd3});
        for (int i = 0; i < 3; i++) begin
            tick();
            check("seq130_idle", {busy, layer_done, load_req}, 0);
        end

        // Reset during RUN of tile 2, then immediate restart with a different layer.
        start_layer(130, 40, 20, 2, 1);
        run_tile(0, 0, 0, 0, 0, 0, t_oc, t_h, ob, rb);
        run_tile(0, 0, 0, 0, 0, 0, t_oc, t_h, ob, rb);
        run_tile(0, 0, 0, 0, 0, 1, t_oc, t_h, ob, rb);
        tick();
        check("reset_held_outs", all_outs(), 0);
        reset = 1'b0;
        start_layer(65, 33, 11, 4, 2);
        check("post_reset_accept", {busy, load_req, pe_w}, {2'b11, 6'd11});
        for (int t = 0; t < 4; t++) begin
            run_tile(0, 0, 0, t == 3, 0, 0, t_oc, t_h, ob, rb);
            check("seq65_tile", {t_oc, t_h, ob, rb},
                  {8'(seq65[t].t_oc), 6'(seq65[t].t_h), 10'(seq65[t].ob), 8'(seq65[t].rb)});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
